// File: rtl/blaster_multivib_pkg.sv
// Shared types, parameter defaults/limits and a range helper for blaster_multivibrator.
package blaster_multivib_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } chan_state_e;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam int CH_NUM_DEF      = 4;
    localparam int CH_NUM_MIN      = 1;
    localparam int CH_NUM_MAX      = 32;
    localparam int BIT_WIDTH_DEF   = 6;
    localparam int BIT_WIDTH_MIN   = 1;
    localparam int BIT_WIDTH_MAX   = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/blaster_multivibrator_if.sv
// Strobe/enable/length inputs and pulse/done outputs of blaster_multivibrator.
interface blaster_multivibrator_if
    import blaster_multivib_pkg::*;
#(
    parameter int CH_NUM    = CH_NUM_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF
);
    logic [CH_NUM-1:0]           i_strobe;
    logic [CH_NUM-1:0]           i_en;
    logic [CH_NUM*BIT_WIDTH-1:0] i_data_pulse;
    logic [CH_NUM-1:0]           o_out;
    logic [CH_NUM-1:0]           o_done;

    modport master (
        output i_strobe, i_en, i_data_pulse,
        input  o_out, o_done
    );

    modport slave (
        input  i_strobe, i_en, i_data_pulse,
        output o_out, o_done
    );
endinterface

// File: rtl/blaster_multivib_channel.sv
// One pulse-stretch channel: strobe synchronizer, rising-edge detector, IDLE/ACTIVE FSM, counter.
// Retrigger-while-active is enabled by defining BLASTER_MULTIVIB_RETRIGGER_EN.
module blaster_multivib_channel
    import blaster_multivib_pkg::*;
#(
    parameter int BIT_WIDTH   = BIT_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_strobe,
    input  logic                 i_en,
    input  logic [BIT_WIDTH-1:0] i_len,
    output logic                 o_out,
    output logic                 o_done
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_edge;
    logic                   r_trig;
    logic [0:0]             r_state;
    logic [BIT_WIDTH-1:0]   r_cnt;
    logic                   r_out;
    logic                   r_done;

    logic [0:0]             w_state_nxt;
    logic [BIT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_out_nxt;
    logic                   w_done_nxt;

    // Synchronizer and edge detector; r_vld stops reset-time zeros from looking like a real low sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_vld  <= '0;
            r_edge <= 1'b1;
            r_trig <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_strobe};
            r_vld  <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_edge <= r_vld[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1] : 1'b1;
            r_trig <= r_vld[SYNC_STAGES-1] & r_sync[SYNC_STAGES-1] & ~r_edge;
        end
    end

    // Next-state logic for the pulse FSM and length counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_trig) begin
                        w_state_nxt = ST_ACTIVE;
                        w_cnt_nxt   = i_len;
                        w_out_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
`ifdef BLASTER_MULTIVIB_RETRIGGER_EN
                    if (r_trig) begin
                        w_cnt_nxt = i_len;
                        w_out_nxt = 1'b1;
                    end else
`endif
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - BIT_WIDTH'(1);
                        w_out_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_out  = r_out;
    assign o_done = r_done;

endmodule

// File: rtl/blaster_multivibrator.sv
// Multi-channel retriggerable/non-retriggerable pulse stretcher top.
// Optional macro: BLASTER_MULTIVIB_RETRIGGER_EN (retrigger while a pulse is active).
module blaster_multivibrator
    import blaster_multivib_pkg::*;
#(
    parameter int CH_NUM      = CH_NUM_DEF,
    parameter int BIT_WIDTH   = BIT_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    blaster_multivibrator_if.slave  bus
);

    if (!in_range(CH_NUM, CH_NUM_MIN, CH_NUM_MAX) ||
        !in_range(BIT_WIDTH, BIT_WIDTH_MIN, BIT_WIDTH_MAX) ||
        !in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_param_err
        $fatal(1, "blaster_multivibrator: CH_NUM/BIT_WIDTH/SYNC_STAGES out of range");
    end

    logic [CH_NUM-1:0] w_out;
    logic [CH_NUM-1:0] w_done;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        blaster_multivib_channel #(
            .BIT_WIDTH   (BIT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_strobe (bus.i_strobe[c]),
            .i_en     (bus.i_en[c]),
            .i_len    (bus.i_data_pulse[c*BIT_WIDTH +: BIT_WIDTH]),
            .o_out    (w_out[c]),
            .o_done   (w_done[c])
        );
    end

    assign bus.o_out  = w_out;
    assign bus.o_done = w_done;

endmodule

// File: doc/blaster_multivibrator.md
BLASTER_MULTIVIBRATOR -- requirements
Module: blaster_multivibrator

Interface
REQ-001 Parameter CH_NUM, default 4, number of independent pulse-stretch channels (1..32).
REQ-002 Parameter BIT_WIDTH, default 6, width of each pulse-length word.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for strobe inputs (2..4).
REQ-004 i_clk  input  1  single clock; all logic sampled on posedge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_strobe  input  CH_NUM  per-channel strobe, asynchronous to i_clk.
REQ-007 i_en  input  CH_NUM  per-channel enable, synchronous.
REQ-008 i_data_pulse  input  CH_NUM*BIT_WIDTH  per-channel length L; channel c uses bits [c*BIT_WIDTH +: BIT_WIDTH].
REQ-009 o_out  output  CH_NUM  stretched pulse, registered.
REQ-010 o_done  output  CH_NUM  one-cycle strobe when a pulse ends normally, registered.

Function
REQ-011 Each i_strobe bit SHALL pass through SYNC_STAGES flops, then a rising-edge detector register; trig[c] is high for exactly one cycle per synchronized 0->1 transition.
REQ-012 Latency: o_out[c] SHALL rise on the (SYNC_STAGES+2)th i_clk posedge after the first posedge sampling i_strobe[c] high.
REQ-013 Per-channel states: IDLE, ACTIVE.
REQ-014 IDLE + trig + i_en: load counter with i_data_pulse[c] sampled in the trig cycle; go ACTIVE; o_out=1 next cycle.
REQ-015 ACTIVE: counter decrements once per cycle; o_out stays high for exactly L+1 cycles (L=0 -> 1 cycle; L=2^BIT_WIDTH-1 -> 2^BIT_WIDTH cycles, no wrap).
REQ-016 ACTIVE, counter==0, no trig: go IDLE, o_out=0, o_done=1 for that single cycle.
REQ-017 i_en[c] low: channel forced IDLE at next posedge, o_out=0, o_done stays 0, counter cleared; trigs while disabled are discarded; synchronizer keeps running.
REQ-018 Changes to i_data_pulse while ACTIVE SHALL NOT affect the running pulse, except on retrigger (REQ-021).
REQ-019 Channels fully independent; simultaneous trigs on several channels each handled per REQ-014.
REQ-020 Strobe high on reset release SHALL NOT trigger (edge detector reset state = synchronized value assumed 1 until first sample... i.e., edge register resets to 1).

Reset
REQ-022 While i_rst_n=0: all synchronizer flops 0, edge register 1, counters 0, state IDLE, o_out=0, o_done=0.
REQ-023 Reset asserted mid-pulse SHALL drop o_out immediately (asynchronously) without an o_done.
REQ-024 First trig possible only after a synchronized 0 then 1 is seen following reset release.

Configuration
REQ-021 Macro BLASTER_MULTIVIB_RETRIGGER_EN defined: trig while ACTIVE reloads counter with current i_data_pulse[c]; o_out remains high with no gap; no o_done; trig in the counter==0 cycle also reloads (retrigger wins over expiry).
REQ-025 Macro undefined: trig while ACTIVE (including counter==0 cycle) SHALL be ignored and lost; pulse ends per REQ-016.

Structure
REQ-026 Package blaster_multivib_pkg SHALL hold the state enum (IDLE, ACTIVE) and the default/limit constants for CH_NUM, BIT_WIDTH, SYNC_STAGES.
REQ-027 Per-channel logic SHALL be sub-module blaster_multivib_channel (synchronizer, edge detect, FSM, counter), instantiated CH_NUM times via generate.
REQ-028 Top SHALL elaborate-time check parameter ranges and stop on violation.

Verification
REQ-029 CH_NUM=4, BIT_WIDTH=6, SYNC_STAGES=2; ch0 L=5, strobe pulse 3 cycles -> o_out[0] rises 4 posedges after first sample, high exactly 6 cycles, o_done[0] one cycle at fall.
REQ-030 L=0 and L=63 on ch1 -> o_out high 1 and 64 cycles respectively, no wrap, one o_done each.
REQ-031 ch2 L=10, second strobe edge 4 cycles into pulse -> with macro: high 4+11 cycles, one o_done; without: high 11 cycles, second edge ignored.
REQ-032 ch3 active with L=20, i_en[3] dropped at cycle 5 -> o_out[3]=0 next posedge, no o_done; strobe while disabled produces nothing.
REQ-033 i_rst_n pulsed low mid-pulse on all channels with strobes held high across release -> all outputs 0 asynchronously, no trigger after release until strobes go low then high.
REQ-034 Random async strobes on all 4 channels for 10k cycles vs reference model -> exact o_out/o_done match, channels independent.
